// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and frame constants for the instruction-memory loader
package imem_loader_pkg;
   typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, CHK, RUN, ERR} state_t;
   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_W = 16;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// loader_word_assembler: gathers bytes into little-endian 32-bit words, pulsing word_done on the last lane
module loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_done
);
   localparam int LANE_W = $clog2(BYTES_PER_WORD);
   logic [LANE_W-1:0] lane;
   logic [23:0] partial;
   assign word = {data, partial};
   assign word_done = accept && lane == LANE_W'(BYTES_PER_WORD - 1);
   // shift each accepted byte in from the top so the first byte lands in [7:0] after four lanes
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         lane <= '0;
         partial <= '0;
      end else if (clear) begin
         lane <= '0;
         partial <= '0;
      end else if (accept) begin
         lane <= lane + 1'b1;
         partial <= word[31:8];
      end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer that holds the core in reset until a framed image is loaded
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              load_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t FIN = CHK;
   logic [7:0] csum;
`else
   localparam state_t FIN = RUN;
`endif
   state_t state, next;
   logic [CNT_W-1:0] count, count_now;
   logic [ADDR_W-3:0] idx;
   logic [31:0] word;
   logic accept, data_accept, clear, word_done, last_word;
   assign in_ready = !(state == RUN || state == ERR);
   assign accept = in_valid && in_ready;
   assign data_accept = accept && state == DATA;
   assign clear = load_req && !in_ready;
   assign count_now = {in_data, count[7:0]};
   assign last_word = CNT_W'(idx) == count - CNT_W'(1);
   assign core_reset = state != RUN;
   assign done = state == RUN;
   assign error = state == ERR;
   loader_word_assembler u_asm (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .accept(data_accept),
      .data(in_data),
      .word(word),
      .word_done(word_done)
   );
   // frame sequencing: count bytes, data words, optional checksum, then hold in RUN or ERR
   always_comb begin
      next = state;
      unique case (state)
         CNT_LO: next = accept ? CNT_HI : state;
         CNT_HI: if (accept) next = count_now == '0 ? FIN : count_now > CNT_W'(DEPTH_WORDS) ? ERR : DATA;
         DATA: if (word_done && last_word) next = FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK: if (accept) next = in_data == csum ? RUN : ERR;
`endif
         RUN, ERR: if (load_req) next = CNT_LO;
         default: next = CNT_LO;
      endcase
   end
   // state, count capture, word index, checksum and registered memory write port
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= CNT_LO;
         count <= '0;
         idx <= '0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
      end else begin
         state <= next;
         mem_we <= word_done;
         if (word_done) begin
            mem_addr <= {idx, 2'b00};
            mem_wdata <= word;
         end
         if (accept && state == CNT_LO) count[7:0] <= in_data;
         if (accept && state == CNT_HI) count[15:8] <= in_data;
         if (clear) idx <= '0;
         else if (word_done) idx <= idx + 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
   // running XOR over data bytes only
   always_ff @(posedge clk or negedge reset)
      if (!reset) csum <= '0;
      else if (clear) csum <= '0;
      else if (data_accept) csum <= csum ^ in_data;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus checked every cycle against a byte-position model of the loader
module tb_imem_loader;
   localparam int DEPTH = 128;
   localparam int AW = 9;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, load_req = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic in_ready, mem_we, core_reset, done, error;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .load_req(load_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_reset(core_reset), .done(done), .error(error)
   );
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: k counts accepted bytes of the current frame; outputs follow from its position
   int k = 0, n = 0, md = 0;
   bit m_run = 1'b0, m_err = 1'b0, e_we = 1'b0;
   logic [7:0] lo = 8'h00, x = 8'h00;
   logic [31:0] wbuf = 32'h0, e_wdata = 32'h0, e_addr = 32'h0;
   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         k = 0; n = 0; m_run = 1'b0; m_err = 1'b0; e_we = 1'b0; e_addr = 0; e_wdata = 0; x = 0;
      end else begin
         e_we = 1'b0;
         if (m_run || m_err) begin
            if (load_req) begin m_run = 1'b0; m_err = 1'b0; k = 0; x = 0; end
         end else if (in_valid) begin
            if (k == 0) lo = in_data;
            else if (k == 1) begin
               n = int'({in_data, lo});
               if (n > DEPTH) m_err = 1'b1;
               else if (n == 0) m_run = !CSUM;
            end else if (k - 2 < 4 * n) begin
               md = k - 2;
               x = x ^ in_data;
               wbuf[8 * (md % 4) +: 8] = in_data;
               if (md % 4 == 3) begin
                  e_we = 1'b1;
                  e_addr = 32'(4 * (md / 4));
                  e_wdata = wbuf;
                  if (md / 4 == n - 1) m_run = !CSUM;
               end
            end else if (in_data == x) m_run = 1'b1;
            else m_err = 1'b1;
            k++;
         end
      end
   end
   // per-cycle comparison plus a log of observed writes
   logic [AW-1:0] la[$];
   logic [31:0] ld[$];
   logic lc[$];
   initial forever begin
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(!(m_run || m_err)));
      check("core_reset", 32'(core_reset), 32'(!m_run));
      check("done", 32'(done), 32'(m_run));
      check("error", 32'(error), 32'(m_err));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_addr", 32'(mem_addr), 32'(e_addr[AW-1:0]));
      check("mem_wdata", mem_wdata, e_wdata);
      if (mem_we) begin la.push_back(mem_addr); ld.push_back(mem_wdata); lc.push_back(core_reset); end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b, input int gap);
      in_valid = 1'b1;
      in_data = b;
      step();
      in_valid = 1'b0;
      in_data = 8'($urandom);
      load_req = 1'b0;
      repeat (gap) step();
   endtask
   task automatic pulse_load();
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      step();
   endtask
   logic [31:0] wq[$];
   logic [7:0] fr[$];
   task automatic mk_frame(input int cnt);
      logic [7:0] c = 8'h00;
      fr = {};
      fr.push_back(cnt[7:0]);
      fr.push_back(cnt[15:8]);
      foreach (wq[i])
         for (int j = 0; j < 4; j++) begin
            fr.push_back(wq[i][8 * j +: 8]);
            c = c ^ wq[i][8 * j +: 8];
         end
      if (CSUM) fr.push_back(c);
   endtask
   task automatic send_frame(input int gap, input bit rnd);
      foreach (fr[i]) begin
         if (rnd) load_req = $urandom_range(7, 0) == 0;
         send(fr[i], rnd ? int'($urandom_range(gap, 0)) : gap);
      end
      step();
   endtask
   initial begin
      repeat (3) step();
      check("rst in_ready", 32'(in_ready), 1);
      check("rst core_reset", 32'(core_reset), 1);
      check("rst done", 32'(done), 0);
      check("rst mem_addr", 32'(mem_addr), 0);
      reset = 1'b1;
      step();
      // image of two words, back to back then with stalls
      for (int g = 0; g < 4; g += 3) begin
         la.delete(); ld.delete(); lc.delete();
         wq = {32'h00100513, 32'h00200593};
         mk_frame(2);
         send_frame(g, 1'b0);
         check("img writes", 32'(la.size()), 2);
         if (la.size() == 2) begin
            check("img addr0", 32'(la[0]), 0);
            check("img data0", ld[0], 32'h00100513);
            check("img cr0", 32'(lc[0]), 1);
            check("img addr1", 32'(la[1]), 4);
            check("img data1", ld[1], 32'h00200593);
            check("img cr1", 32'(lc[1]), 0);
         end
         check("img done", 32'(done), 1);
         pulse_load();
      end
      // oversize count
      la.delete();
      send(8'h81, 0);
      send(8'h00, 1);
      check("big error", 32'(error), 1);
      check("big in_ready", 32'(in_ready), 0);
      check("big core_reset", 32'(core_reset), 1);
      check("big writes", 32'(la.size()), 0);
      pulse_load();
      check("reload in_ready", 32'(in_ready), 1);
      // async reset after six bytes, right as the first write appears
      wq = {$urandom, $urandom};
      mk_frame(2);
      for (int i = 0; i < 6; i++) send(fr[i], 0);
      reset = 1'b0;
      #1;
      check("abort mem_we", 32'(mem_we), 0);
      check("abort mem_wdata", mem_wdata, 0);
      check("abort core_reset", 32'(core_reset), 1);
      step();
      reset = 1'b1;
      step();
      la.delete(); ld.delete();
      wq = {32'hcafe0001};
      mk_frame(1);
      send_frame(1, 1'b0);
      check("fresh writes", 32'(la.size()), 1);
      if (la.size() == 1) check("fresh addr", 32'(la[0]), 0);
      // reload from RUN
      pulse_load();
      check("reload core_reset", 32'(core_reset), 1);
      check("reload done", 32'(done), 0);
      la.delete(); ld.delete();
      wq = {32'h00000013};
      mk_frame(1);
      send_frame(0, 1'b0);
      check("reload writes", 32'(la.size()), 1);
      if (la.size() == 1) check("reload data", ld[0], 32'h00000013);
      check("reload run", 32'(done), 1);
      pulse_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      wq = {32'h00100513};
      mk_frame(1);
      check("csum byte", 32'(fr[6]), 32'h06);
      send_frame(0, 1'b0);
      check("csum ok done", 32'(done), 1);
      pulse_load();
      fr[6] = 8'h07;
      send_frame(0, 1'b0);
      check("csum bad error", 32'(error), 1);
      check("csum bad core_reset", 32'(core_reset), 1);
      pulse_load();
`endif
      // randomized frames including the empty, full and oversize boundaries
      for (int r = 0; r < 24; r++) begin
         int p, cnt;
         p = int'($urandom_range(9, 0));
         cnt = p == 0 ? 0 : p == 1 ? 129 + int'($urandom_range(200, 0)) : p == 2 ? (r < 12 ? 128 : 1)
               : int'($urandom_range(6, 1));
         wq = {};
         if (cnt <= DEPTH) for (int i = 0; i < cnt; i++) wq.push_back($urandom);
         mk_frame(cnt);
         if (CSUM && $urandom_range(3, 0) == 0) fr[fr.size() - 1] = fr[fr.size() - 1] ^ 8'h01;
         send_frame(2, 1'b1);
         send(8'($urandom), 1);
         pulse_load();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
